memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- RV64I MEM stage plus MEM/WB pipeline register. Sits between execute and writeback and directly feeds the writeback mux (ALUResult_W, ReadData_W, PCPlus4_W, ResultSrc_W).
- Drives a variable-latency data memory over a req/response handshake.
- Generates store byte-enables, sign/zero-extends loads and detects misalignment.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.
- RESET_PC4, 64'h0, reset value of PCPlus4_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Valid_M  in  1  the MEM slot holds a real instruction.
- ALUResult_M  in  64  effective address or ALU result.
- WriteData_M  in  64  store data (rs2).
- PCPlus4_M  in  64  link value.
- Rd_M  in  5  destination register.
- RegWrite_M  in  1  register write enable.
- ResultSrc_M  in  2  00 ALU, 01 memory, 10 PC+4.
- MemRead_M  in  1  load.
- MemWrite_M  in  1  store.
- Funct3_M  in  3  access size/sign.
- DMemReq  out  1  access request, held until response.
- DMemWe  out  1  1 = store.
- DMemAddr  out  64  doubleword-aligned address, {ALUResult_M[63:3],3'b0}.
- DMemWData  out  64  lane-replicated store data.
- DMemBe  out  8  byte enables.
- DMemRData  in  64  read doubleword.
- DMemRspValid  in  1  response strobe; valid only in BUSY.
- Stall_M  out  1  hold upstream stages and the MEM inputs.
- ALUResult_W  out  64  registered.
- ReadData_W  out  64  registered, extended load data.
- PCPlus4_W  out  64  registered.
- ResultSrc_W  out  2  registered.
- Rd_W  out  5  registered.
- RegWrite_W  out  1  registered.
- Valid_W  out  1  registered.
- Misaligned_W  out  1  registered misaligned/illegal access flag.

Behaviour:
- Reset: asynchronous and active-low.
  - FSM goes to IDLE.
  - All _W outputs are 0, except PCPlus4_W = RESET_PC4.
  - DMemReq, DMemWe, DMemBe and Stall_M are 0.
- Access = Valid_M & (MemRead_M | MemWrite_M).
- Offset = ALUResult_M[2:0].
- Size from Funct3_M[1:0]: 00 byte, 01 half, 10 word, 11 double.
- Misaligned when any of:
  - half with offset[0] set;
  - word with offset[1:0] nonzero;
  - double with offset nonzero;
  - load with Funct3_M = 111;
  - store with Funct3_M[2] set.
- FSM states: IDLE and BUSY.
- IDLE:
  - Non-access or misaligned instruction: no request and Stall_M = 0. The W register captures the instruction on the next edge (1-cycle latency).
  - Misaligned case: Misaligned_W = 1 and RegWrite_W is forced to 0.
  - Legal access: DMemReq = 1 combinationally and Stall_M = 1. Go to BUSY. The W register captures a bubble (Valid_W = 0, RegWrite_W = 0, Misaligned_W = 0).
- BUSY:
  - DMemReq, DMemWe, DMemAddr, DMemBe and DMemWData are held stable; the inputs are stable because Stall_M is held.
  - If DMemRspValid = 0: Stall_M = 1, a bubble enters W, stay in BUSY.
  - If DMemRspValid = 1: Stall_M = 0, W captures the instruction with extended ReadData_W, go to IDLE.
  - Minimum access latency is 2 cycles.
- DMemRspValid asserted in IDLE is ignored.
- Store encoding:
  - DMemBe = sizemask << offset, where sizemask is 01, 03, 0F or FF.
  - DMemWData lane replication: byte x8, half x4, word x2, double as is.
- Load extension:
  - lane = DMemRData >> (offset*8).
  - 000 sign-extends lane[7:0]; 001 sign-extends [15:0]; 010 sign-extends [31:0]; 011 takes all 64 bits.
  - 100, 101, 110 zero-extend 8, 16 and 32 bits respectively.
- ReadData_W = 0 for non-loads.
- Stores pass through W with their RegWrite_M value, which the decoder sets to 0.
- Reset asserted in BUSY aborts the access: DMemReq drops immediately and the response is not awaited.

Decomposition:
- mem_pkg holds:
  - state enum {IDLE, BUSY};
  - funct3 localparams F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU;
  - ResultSrc encodings RS_ALU, RS_MEM, RS_PC4.
- Sub-module load_extend: combinational. Inputs rdata, offset, funct3; output extended data. It is unit-testable alone.

Test Plan:
- Non-memory op: ALUResult_M = AAAA_AAAA_AAAA_AAAA, ResultSrc_M = 00, RegWrite_M = 1 → next cycle ALUResult_W = AAAA..., Valid_W = 1, Stall_M never asserted.
- LB at address 0x1003, DMemRData = 0x0000_0000_8000_0000, response after 3 BUSY cycles →
  - Stall_M high for 4 cycles and DMemAddr = 0x1000;
  - ReadData_W = FFFF_FFFF_FFFF_FF80;
  - bubbles seen on W during the stall.
- LWU at 0x2004, DMemRData = 0x8765_4321_0000_0000, immediate response → ReadData_W = 0x0000_0000_8765_4321 after 2 cycles.
- SH at 0x3006 with WriteData_M = 0xBEEF → DMemBe = 0xC0, DMemWData = BEEF_BEEF_BEEF_BEEF, DMemWe = 1.
- LD at 0x4004 → no DMemReq, Stall_M = 0, next cycle Misaligned_W = 1 and RegWrite_W = 0.
- Reset mid-access: assert rst_n = 0 in BUSY → DMemReq = 0 and Stall_M = 0 immediately. After release, a new SB at 0x10 issues DMemBe = 0x01.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and encodings for the RV64I memory stage: FSM states, load/store
// funct3 codes, writeback result-source selects and access-size helpers.
package mem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  // Byte-enable pattern for an access of the given size, before shifting to its offset.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      2'b11:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] offset, input logic [2:0] funct3,
                                         input logic is_load, input logic is_store);
    logic bad;
    case (funct3[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = offset[0];
      2'b10:   bad = (offset[1:0] != 2'b00);
      2'b11:   bad = (offset != 3'b000);
      default: bad = 1'b1;
    endcase
    if (is_load && (funct3 == 3'b111)) begin
      bad = 1'b1;
    end else if (is_store && funct3[2]) begin
      bad = 1'b1;
    end else begin
      bad = bad;
    end
    return bad;
  endfunction

endpackage

// File: rtl/memory_stage_load_extend.sv
// Combinational load formatter: selects the addressed lane of a read doubleword
// and sign- or zero-extends it according to funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_data
);

  logic [63:0] w_lane;

  assign w_lane = i_rdata >> {i_offset, 3'b000};

  // Size/sign selection; the reserved encoding yields zero.
  always_comb begin
    o_data = 64'd0;
    case (i_funct3)
      F3_B:    o_data = {{56{w_lane[7]}}, w_lane[7:0]};
      F3_H:    o_data = {{48{w_lane[15]}}, w_lane[15:0]};
      F3_W:    o_data = {{32{w_lane[31]}}, w_lane[31:0]};
      F3_D:    o_data = w_lane;
      F3_BU:   o_data = {56'd0, w_lane[7:0]};
      F3_HU:   o_data = {48'd0, w_lane[15:0]};
      F3_WU:   o_data = {32'd0, w_lane[31:0]};
      default: o_data = 64'd0;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV64I MEM stage with MEM/WB register: drives a variable-latency data memory
// through a req/response handshake and stalls upstream while an access is open.
module memory_stage
  import mem_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC4 = 64'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Valid_M,
  input  logic [XLEN-1:0] ALUResult_M,
  input  logic [XLEN-1:0] WriteData_M,
  input  logic [XLEN-1:0] PCPlus4_M,
  input  logic [4:0]      Rd_M,
  input  logic            RegWrite_M,
  input  logic [1:0]      ResultSrc_M,
  input  logic            MemRead_M,
  input  logic            MemWrite_M,
  input  logic [2:0]      Funct3_M,
  output logic            DMemReq,
  output logic            DMemWe,
  output logic [XLEN-1:0] DMemAddr,
  output logic [XLEN-1:0] DMemWData,
  output logic [7:0]      DMemBe,
  input  logic [XLEN-1:0] DMemRData,
  input  logic            DMemRspValid,
  output logic            Stall_M,
  output logic [XLEN-1:0] ALUResult_W,
  output logic [XLEN-1:0] ReadData_W,
  output logic [XLEN-1:0] PCPlus4_W,
  output logic [1:0]      ResultSrc_W,
  output logic [4:0]      Rd_W,
  output logic            RegWrite_W,
  output logic            Valid_W,
  output logic            Misaligned_W
);

  state_e          r_state;
  state_e          w_next;
  logic [2:0]      w_offset;
  logic            w_access;
  logic            w_mis;
  logic            w_mis_acc;
  logic            w_req;
  logic            w_done;
  logic            w_capture;
  logic [7:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_ext;

  assign w_offset  = ALUResult_M[2:0];
  assign w_access  = Valid_M & (MemRead_M | MemWrite_M);
  assign w_mis     = is_misaligned(w_offset, Funct3_M, MemRead_M, MemWrite_M);
  assign w_mis_acc = w_access & w_mis & (r_state == IDLE);
  assign w_done    = (r_state == BUSY) & DMemRspValid;

  // Request is qualified with rst_n so an aborted access drops it the moment reset asserts.
  assign w_req     = rst_n & (((r_state == IDLE) & w_access & ~w_mis) | (r_state == BUSY));
  assign w_capture = ((r_state == IDLE) & ~(w_access & ~w_mis)) | w_done;
  assign w_be      = size_mask(Funct3_M[1:0]) << w_offset;

  assign DMemReq   = w_req;
  assign DMemWe    = w_req & MemWrite_M;
  assign DMemBe    = w_req ? w_be : 8'h00;
  assign DMemAddr  = {ALUResult_M[XLEN-1:3], 3'b000};
  assign DMemWData = w_wdata;
  assign Stall_M   = w_req & ~w_done;

  // Store data replicated across every lane so the byte enables alone pick the target bytes.
  always_comb begin
    w_wdata = WriteData_M;
    case (Funct3_M[1:0])
      2'b00:   w_wdata = {8{WriteData_M[7:0]}};
      2'b01:   w_wdata = {4{WriteData_M[15:0]}};
      2'b10:   w_wdata = {2{WriteData_M[31:0]}};
      2'b11:   w_wdata = WriteData_M;
      default: w_wdata = WriteData_M;
    endcase
  end

  load_extend u_load_extend (
    .i_rdata  (DMemRData),
    .i_offset (w_offset),
    .i_funct3 (Funct3_M),
    .o_data   (w_ext)
  );

  // Access FSM next-state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_access && !w_mis) ? BUSY : IDLE;
      BUSY:    w_next = DMemRspValid ? IDLE : BUSY;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // MEM/WB register; cycles without a completed instruction insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResult_W  <= '0;
      ReadData_W   <= '0;
      PCPlus4_W    <= RESET_PC4;
      ResultSrc_W  <= 2'b00;
      Rd_W         <= 5'd0;
      RegWrite_W   <= 1'b0;
      Valid_W      <= 1'b0;
      Misaligned_W <= 1'b0;
    end else begin
      ALUResult_W <= ALUResult_M;
      PCPlus4_W   <= PCPlus4_M;
      ResultSrc_W <= ResultSrc_M;
      Rd_W        <= Rd_M;
      if (w_capture) begin
        Valid_W      <= Valid_M;
        RegWrite_W   <= Valid_M & RegWrite_M & ~w_mis_acc;
        Misaligned_W <= w_mis_acc;
        ReadData_W   <= (w_done && MemRead_M) ? w_ext : '0;
      end else begin
        Valid_W      <= 1'b0;
        RegWrite_W   <= 1'b0;
        Misaligned_W <= 1'b0;
        ReadData_W   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: ALU pass-through, stalled and
// immediate loads, store encoding, misalignment and reset during an access.
module tb_memory_stage;

  logic        clk;
  logic        rst_n;
  logic        Valid_M;
  logic [63:0] ALUResult_M;
  logic [63:0] WriteData_M;
  logic [63:0] PCPlus4_M;
  logic [4:0]  Rd_M;
  logic        RegWrite_M;
  logic [1:0]  ResultSrc_M;
  logic        MemRead_M;
  logic        MemWrite_M;
  logic [2:0]  Funct3_M;
  logic        DMemReq;
  logic        DMemWe;
  logic [63:0] DMemAddr;
  logic [63:0] DMemWData;
  logic [7:0]  DMemBe;
  logic [63:0] DMemRData;
  logic        DMemRspValid;
  logic        Stall_M;
  logic [63:0] ALUResult_W;
  logic [63:0] ReadData_W;
  logic [63:0] PCPlus4_W;
  logic [1:0]  ResultSrc_W;
  logic [4:0]  Rd_W;
  logic        RegWrite_W;
  logic        Valid_W;
  logic        Misaligned_W;

  int checks = 0;
  int errors = 0;

  memory_stage #(.XLEN(64), .RESET_PC4(64'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Valid_M      (Valid_M),
    .ALUResult_M  (ALUResult_M),
    .WriteData_M  (WriteData_M),
    .PCPlus4_M    (PCPlus4_M),
    .Rd_M         (Rd_M),
    .RegWrite_M   (RegWrite_M),
    .ResultSrc_M  (ResultSrc_M),
    .MemRead_M    (MemRead_M),
    .MemWrite_M   (MemWrite_M),
    .Funct3_M     (Funct3_M),
    .DMemReq      (DMemReq),
    .DMemWe       (DMemWe),
    .DMemAddr     (DMemAddr),
    .DMemWData    (DMemWData),
    .DMemBe       (DMemBe),
    .DMemRData    (DMemRData),
    .DMemRspValid (DMemRspValid),
    .Stall_M      (Stall_M),
    .ALUResult_W  (ALUResult_W),
    .ReadData_W   (ReadData_W),
    .PCPlus4_W    (PCPlus4_W),
    .ResultSrc_W  (ResultSrc_W),
    .Rd_W         (Rd_W),
    .RegWrite_W   (RegWrite_W),
    .Valid_W      (Valid_W),
    .Misaligned_W (Misaligned_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Valid_M      = 1'b0;
    ALUResult_M  = 64'd0;
    WriteData_M  = 64'd0;
    PCPlus4_M    = 64'd0;
    Rd_M         = 5'd0;
    RegWrite_M   = 1'b0;
    ResultSrc_M  = 2'b00;
    MemRead_M    = 1'b0;
    MemWrite_M   = 1'b0;
    Funct3_M     = 3'b000;
    DMemRData    = 64'd0;
    DMemRspValid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #3;
    chk("rst_valid_w", {63'd0, Valid_W}, 64'd0);
    chk("rst_regwrite_w", {63'd0, RegWrite_W}, 64'd0);
    chk("rst_pc4_w", PCPlus4_W, 64'h0);
    chk("rst_alu_w", ALUResult_W, 64'd0);
    chk("rst_req", {63'd0, DMemReq}, 64'd0);
    chk("rst_stall", {63'd0, Stall_M}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU op, with a stray response strobe that must be ignored in IDLE
    Valid_M = 1'b1; ALUResult_M = 64'hAAAA_AAAA_AAAA_AAAA; RegWrite_M = 1'b1;
    Rd_M = 5'd5; PCPlus4_M = 64'h104; DMemRspValid = 1'b1;
    #1;
    chk("alu_stall", {63'd0, Stall_M}, 64'd0);
    chk("alu_req", {63'd0, DMemReq}, 64'd0);
    tick();
    chk("alu_alu_w", ALUResult_W, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("alu_valid_w", {63'd0, Valid_W}, 64'd1);
    chk("alu_regwrite_w", {63'd0, RegWrite_W}, 64'd1);
    chk("alu_rd_w", {59'd0, Rd_W}, 64'd5);
    chk("alu_pc4_w", PCPlus4_W, 64'h104);
    chk("alu_rdata_w", ReadData_W, 64'd0);

    // LB at 0x1003, response in the fourth BUSY cycle
    idle_inputs();
    Valid_M = 1'b1; ALUResult_M = 64'h1003; MemRead_M = 1'b1; RegWrite_M = 1'b1;
    Rd_M = 5'd7; ResultSrc_M = 2'b01; Funct3_M = 3'b000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lb_stall", {63'd0, Stall_M}, 64'd1);
      chk("lb_req", {63'd0, DMemReq}, 64'd1);
      chk("lb_addr", DMemAddr, 64'h1000);
      chk("lb_we", {63'd0, DMemWe}, 64'd0);
      tick();
      chk("lb_bubble_valid", {63'd0, Valid_W}, 64'd0);
      chk("lb_bubble_regwrite", {63'd0, RegWrite_W}, 64'd0);
    end
    DMemRData = 64'h0000_0000_8000_0000; DMemRspValid = 1'b1;
    #1;
    chk("lb_rsp_stall", {63'd0, Stall_M}, 64'd0);
    chk("lb_rsp_req", {63'd0, DMemReq}, 64'd1);
    tick();
    DMemRspValid = 1'b0;
    chk("lb_rdata_w", ReadData_W, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_valid_w", {63'd0, Valid_W}, 64'd1);
    chk("lb_regwrite_w", {63'd0, RegWrite_W}, 64'd1);
    chk("lb_rd_w", {59'd0, Rd_W}, 64'd7);
    chk("lb_rsrc_w", {62'd0, ResultSrc_W}, 64'd1);

    // LWU at 0x2004, immediate response
    idle_inputs();
    Valid_M = 1'b1; ALUResult_M = 64'h2004; MemRead_M = 1'b1; RegWrite_M = 1'b1;
    Rd_M = 5'd9; ResultSrc_M = 2'b01; Funct3_M = 3'b110;
    #1;
    chk("lwu_stall", {63'd0, Stall_M}, 64'd1);
    chk("lwu_be", {56'd0, DMemBe}, 64'hF0);
    tick();
    DMemRData = 64'h8765_4321_0000_0000; DMemRspValid = 1'b1;
    tick();
    DMemRspValid = 1'b0;
    chk("lwu_rdata_w", ReadData_W, 64'h0000_0000_8765_4321);
    chk("lwu_valid_w", {63'd0, Valid_W}, 64'd1);

    // SH at 0x3006
    idle_inputs();
    Valid_M = 1'b1; ALUResult_M = 64'h3006; MemWrite_M = 1'b1; WriteData_M = 64'hBEEF;
    Funct3_M = 3'b001;
    #1;
    chk("sh_be", {56'd0, DMemBe}, 64'hC0);
    chk("sh_wdata", DMemWData, 64'hBEEF_BEEF_BEEF_BEEF);
    chk("sh_we", {63'd0, DMemWe}, 64'd1);
    chk("sh_addr", DMemAddr, 64'h3000);
    tick();
    chk("sh_busy_be", {56'd0, DMemBe}, 64'hC0);
    DMemRspValid = 1'b1;
    tick();
    DMemRspValid = 1'b0;
    chk("sh_valid_w", {63'd0, Valid_W}, 64'd1);
    chk("sh_regwrite_w", {63'd0, RegWrite_W}, 64'd0);
    chk("sh_rdata_w", ReadData_W, 64'd0);

    // LD at 0x4004 is misaligned
    idle_inputs();
    Valid_M = 1'b1; ALUResult_M = 64'h4004; MemRead_M = 1'b1; RegWrite_M = 1'b1;
    Funct3_M = 3'b011;
    #1;
    chk("ld_mis_req", {63'd0, DMemReq}, 64'd0);
    chk("ld_mis_stall", {63'd0, Stall_M}, 64'd0);
    tick();
    chk("ld_mis_flag", {63'd0, Misaligned_W}, 64'd1);
    chk("ld_mis_regwrite", {63'd0, RegWrite_W}, 64'd0);
    chk("ld_mis_valid", {63'd0, Valid_W}, 64'd1);

    // Store with funct3[2] set is illegal even when aligned
    idle_inputs();
    Valid_M = 1'b1; ALUResult_M = 64'h20; MemWrite_M = 1'b1; Funct3_M = 3'b100;
    #1;
    chk("sbu_req", {63'd0, DMemReq}, 64'd0);
    tick();
    chk("sbu_mis_flag", {63'd0, Misaligned_W}, 64'd1);

    // Reset while BUSY aborts the access
    idle_inputs();
    Valid_M = 1'b1; ALUResult_M = 64'h5000; MemRead_M = 1'b1; RegWrite_M = 1'b1;
    Funct3_M = 3'b010;
    tick();
    chk("abort_busy_req", {63'd0, DMemReq}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_req", {63'd0, DMemReq}, 64'd0);
    chk("abort_stall", {63'd0, Stall_M}, 64'd0);
    chk("abort_be", {56'd0, DMemBe}, 64'd0);
    chk("abort_valid_w", {63'd0, Valid_W}, 64'd0);
    #1;
    rst_n = 1'b1;
    idle_inputs();
    Valid_M = 1'b1; ALUResult_M = 64'h10; MemWrite_M = 1'b1; WriteData_M = 64'h5A;
    Funct3_M = 3'b000;
    #1;
    chk("post_sb_be", {56'd0, DMemBe}, 64'h01);
    chk("post_sb_wdata", DMemWData, 64'h5A5A_5A5A_5A5A_5A5A);
    chk("post_sb_req", {63'd0, DMemReq}, 64'd1);
    tick();
    DMemRspValid = 1'b1;
    tick();
    idle_inputs();
    chk("post_sb_valid_w", {63'd0, Valid_W}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
